// File: rtl/bram_dp_param.sv
// rtl/bram_dp_param.sv - parameterised true dual-port RAM with byte enables and reset-driven clear sequencer
// Optional: define BRAM_OUTREG_EN to add an output register stage (read latency 2).
module bram_dp_param #(
    parameter int             DATA_W   = 8,
    parameter int             ADDR_W   = 15,
    parameter logic [7:0]     FILL_VAL = 8'hEE,
    parameter int             RD_MODE  = 0,
    localparam int            NB       = DATA_W / 8
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              ena,
    input  logic [NB-1:0]     wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    input  logic              enb,
    input  logic [NB-1:0]     web,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dinb,
    output logic [DATA_W-1:0] doutb,
    output logic              busy,
    output logic              collision
);

    localparam int            DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   old_a, old_b, new_a, new_b, rdata_a, rdata_b;
    logic [DATA_W-1:0]   dout_a1, dout_b1;
    logic                run;
    logic                clearing;

    assign clearing = (state_q == CLEAR) && !rsta;
    assign run      = (state_q == RUN) && !rsta;
    assign busy     = rsta || (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        if (rsta)
            state_d = CLEAR;
        else if (state_q == CLEAR && clr_cnt == CLR_LAST)
            state_d = RUN;
    end

    always_ff @(posedge clka) begin
        state_q <= state_d;
        if (rsta)
            clr_cnt <= '0;
        else if (state_q == CLEAR)
            clr_cnt <= clr_cnt + 1'b1;
    end

    // Port B lanes are written first so port A overrides overlapping lanes.
    always_ff @(posedge clka) begin
        if (clearing) begin
            mem[clr_cnt[ADDR_W-1:0]] <= {NB{FILL_VAL}};
        end else if (run) begin
            for (int i = 0; i < NB; i++) begin
                if (enb && web[i])
                    mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
                if (ena && wea[i])
                    mem[addra][8*i +: 8] <= dina[8*i +: 8];
            end
        end
    end

    // Write-first forwarding applies only to the port's own written lanes.
    always_comb begin
        old_a = mem[addra];
        old_b = mem[addrb];
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (wea[i]) new_a[8*i +: 8] = dina[8*i +: 8];
            if (web[i]) new_b[8*i +: 8] = dinb[8*i +: 8];
        end
        rdata_a = (RD_MODE == 1) ? new_a : old_a;
        rdata_b = (RD_MODE == 1) ? new_b : old_b;
    end

    always_ff @(posedge clka) begin
        if (!run) begin
            dout_a1   <= '0;
            dout_b1   <= '0;
            collision <= 1'b0;
        end else begin
            if (ena) dout_a1 <= rdata_a;
            if (enb) dout_b1 <= rdata_b;
            collision <= ena && enb && (addra == addrb) && |(wea & web);
        end
    end

`ifdef BRAM_OUTREG_EN
    logic              ena_q, enb_q;
    logic [DATA_W-1:0] dout_a2, dout_b2;

    always_ff @(posedge clka) begin
        if (!run) begin
            ena_q   <= 1'b0;
            enb_q   <= 1'b0;
            dout_a2 <= '0;
            dout_b2 <= '0;
        end else begin
            ena_q <= ena;
            enb_q <= enb;
            if (ena_q) dout_a2 <= dout_a1;
            if (enb_q) dout_b2 <= dout_b1;
        end
    end

    assign douta = dout_a2;
    assign doutb = dout_b2;
`else
    assign douta = dout_a1;
    assign doutb = dout_b1;
`endif

endmodule
